// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: parametrised pipeline stage register with valid/ready handshake,
// flush, bubble insertion and an optional two-entry skid buffer.
// With SKID=1, ready_o is decoded from the state register only, so it has no
// combinational path from ready_i. With SKID=0, ready_o = ready_i | !valid_o.
module pipe_stage_reg #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 5,
    parameter bit SKID   = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [DATA_W-1:0] data_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [DATA_W-1:0] data_o,
    output logic [CTRL_W-1:0] ctrl_o
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [DATA_W-1:0] main_data_q, skid_data_q;
    logic [CTRL_W-1:0] main_ctrl_q, skid_ctrl_q;

    logic push, pop;
    logic load_main_in;    // main <- upstream entry
    logic load_main_skid;  // main <- skid entry
    logic load_skid;       // skid <- upstream entry
    logic clear_ctrl;      // next state is EMPTY: ctrl storage becomes a bubble

    assign valid_o = (state_q != ST_EMPTY);
    assign data_o  = main_data_q;
    assign ctrl_o  = main_ctrl_q;

    generate
        if (SKID) begin : g_ready_reg
            // Pure decode of the state register: no path from ready_i.
            assign ready_o = (state_q != ST_TWO);
        end else begin : g_ready_comb
            assign ready_o = ready_i | ~valid_o;
        end
    endgenerate

    assign push = valid_i & ready_o;
    assign pop  = valid_o & ready_i;

    // Next-state and storage-load decode; flush overrides every transition.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case statement can leave a value unassigned (no latch).
        state_d        = state_q;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;

        case (state_q)
            ST_EMPTY: begin
                if (push) begin
                    state_d      = ST_ONE;
                    load_main_in = 1'b1;
                end
            end
            ST_ONE: begin
                if (push && pop) begin
                    load_main_in = 1'b1;
                end else if (push && SKID) begin
                    state_d   = ST_TWO;
                    load_skid = 1'b1;
                end else if (pop) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (pop) begin
                    state_d        = ST_ONE;
                    load_main_skid = 1'b1;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase

        // A flushed push is dropped; a flushed pop was already delivered.
        if (flush_i) begin
            state_d        = ST_EMPTY;
            load_main_in   = 1'b0;
            load_main_skid = 1'b0;
            load_skid      = 1'b0;
        end

        clear_ctrl = (state_d == ST_EMPTY);
    end

    // State register with synchronous reset.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (rst_i) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Main entry: drives the outputs; ctrl is zeroed on every entry into EMPTY.
    always_ff @(posedge clk_i) begin
        // NOTE: the data storage is reset on purpose, because data_o must read
        // zero after reset; flush alone leaves data untouched.
        if (rst_i) begin
            main_data_q <= '0;
            main_ctrl_q <= '0;
        end else begin
            if (load_main_in) begin
                main_data_q <= data_i;
            end else if (load_main_skid) begin
                main_data_q <= skid_data_q;
            end

            if (clear_ctrl) begin
                main_ctrl_q <= '0;
            end else if (load_main_in) begin
                main_ctrl_q <= ctrl_i;
            end else if (load_main_skid) begin
                main_ctrl_q <= skid_ctrl_q;
            end
        end
    end

    // Skid entry: absorbs the one entry accepted after back-pressure begins.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            skid_data_q <= '0;
            skid_ctrl_q <= '0;
        end else begin
            if (load_skid) begin
                skid_data_q <= data_i;
            end

            if (clear_ctrl) begin
                skid_ctrl_q <= '0;
            end else if (load_skid) begin
                skid_ctrl_q <= ctrl_i;
            end
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Testbench for pipe_stage_reg: three instances (SKID=1 32/5, SKID=0 32/5,
// SKID=1 64/9) share one stimulus stream. Per instance, the reference model is
// a FIFO of accepted entries: valid_o must equal "FIFO non-empty", ready_o must
// follow the occupancy rule, and every pop must deliver the FIFO head.
module tb_pipe_stage_reg;

    typedef struct packed {
        logic [63:0] d;
        logic [8:0]  c;
    } entry_t;

    logic        clk_i;
    logic        rst_i;
    logic        flush_i;
    logic        valid_i;
    logic        ready_i;
    logic [63:0] din;
    logic [8:0]  cin;
    logic        sb_en;

    logic [2:0]  vout;
    logic [2:0]  rout;
    logic [63:0] dout [3];
    logic [8:0]  cout [3];

    logic [31:0] d0_o, d1_o;
    logic [4:0]  c0_o, c1_o;
    logic [63:0] d2_o;
    logic [8:0]  c2_o;

    int pass_cnt  = 0;
    int total_cnt = 0;

    pipe_stage_reg #(.DATA_W(32), .CTRL_W(5), .SKID(1'b1)) u_skid (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
        .valid_i(valid_i), .ready_o(rout[0]), .data_i(din[31:0]), .ctrl_i(cin[4:0]),
        .valid_o(vout[0]), .ready_i(ready_i), .data_o(d0_o), .ctrl_o(c0_o)
    );

    pipe_stage_reg #(.DATA_W(32), .CTRL_W(5), .SKID(1'b0)) u_noskid (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
        .valid_i(valid_i), .ready_o(rout[1]), .data_i(din[31:0]), .ctrl_i(cin[4:0]),
        .valid_o(vout[1]), .ready_i(ready_i), .data_o(d1_o), .ctrl_o(c1_o)
    );

    pipe_stage_reg #(.DATA_W(64), .CTRL_W(9), .SKID(1'b1)) u_wide (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
        .valid_i(valid_i), .ready_o(rout[2]), .data_i(din), .ctrl_i(cin),
        .valid_o(vout[2]), .ready_i(ready_i), .data_o(d2_o), .ctrl_o(c2_o)
    );

    assign dout[0] = {32'd0, d0_o};
    assign dout[1] = {32'd0, d1_o};
    assign dout[2] = d2_o;
    assign cout[0] = {4'd0, c0_o};
    assign cout[1] = {4'd0, c1_o};
    assign cout[2] = c2_o;

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    function automatic logic [63:0] dmask(input int g);
        return (g == 2) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    endfunction

    function automatic logic [8:0] cmask(input int g);
        return (g == 2) ? 9'h1FF : 9'h01F;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Per-instance scoreboard: monitor at the falling edge, ingress capture 1 ns later.
    for (genvar g = 0; g < 3; g++) begin : g_sb
        entry_t q[$];
        entry_t head;
        int     occ;
        logic   exp_rdy;

        // Monitor: compare outputs against the model FIFO, pop on delivery.
        always @(negedge clk_i) begin
            if (sb_en) begin
                occ     = q.size();
                exp_rdy = (g != 1) ? (occ < 2) : (ready_i || occ == 0);
                check($sformatf("valid_o[%0d]", g), 64'(vout[g]), 64'(occ > 0));
                check($sformatf("ready_o[%0d]", g), 64'(rout[g]), 64'(exp_rdy));
                if (!vout[g]) begin
                    check($sformatf("bubble_ctrl[%0d]", g), 64'(cout[g]), 64'd0);
                end
                if (vout[g] && ready_i && occ > 0) begin
                    head = q.pop_front();
                    check($sformatf("data_o[%0d]", g), dout[g], head.d);
                    check($sformatf("ctrl_o[%0d]", g), 64'(cout[g]), 64'(head.c));
                end
            end
        end

        // Ingress: record accepted entries; flush/reset empties the model.
        always @(negedge clk_i) begin
            if (sb_en) begin
                #1;
                if (rst_i || flush_i) begin
                    q.delete();
                end else if (valid_i && rout[g]) begin
                    q.push_back('{d: din & dmask(g), c: cin & cmask(g)});
                end
            end
        end
    end

    // Apply one cycle of inputs, then return 1 ns after the capturing edge.
    task automatic drive(input logic v, input logic r, input logic f, input logic rs,
                         input logic [63:0] d, input logic [8:0] c);
        valid_i = v;
        ready_i = r;
        flush_i = f;
        rst_i   = rs;
        din     = d;
        cin     = c;
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b1, 1'b0, 1'b0, 64'd0, 9'd0);
    endtask

    task automatic check_reset_values(input string tag);
        for (int g = 0; g < 3; g++) begin
            check($sformatf("%s_valid[%0d]", tag, g), 64'(vout[g]), 64'd0);
            check($sformatf("%s_ready[%0d]", tag, g), 64'(rout[g]), 64'd1);
            check($sformatf("%s_data[%0d]", tag, g), dout[g], 64'd0);
            check($sformatf("%s_ctrl[%0d]", tag, g), 64'(cout[g]), 64'd0);
        end
    endtask

    initial begin
        sb_en = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 1'b1, 64'hDEAD_BEEF_DEAD_BEEF, 9'h1FF);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 64'd0, 9'd0);
        check_reset_values("reset");
        sb_en = 1'b1;

        // Stream of 8 entries at full throughput.
        for (int k = 0; k < 8; k++) drive(1'b1, 1'b1, 1'b0, 1'b0, 64'(32'h100 + k), 9'b0_0001_0011);
        idle(3);

        // Back-pressure: A, B, C offered while ready_i=0, then released.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 64'hA, 9'h0A);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 64'hB, 9'h0B);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 64'hC, 9'h0C);
        check("skid_hold_A", dout[0], 64'hA);
        check("skid_full_ready", 64'(rout[0]), 64'd0);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 64'hC, 9'h0C);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 64'hC, 9'h0C);
        idle(3);

        // Flush in TWO (valid_i high but not accepted), then flush with a real push in ONE.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 64'h11, 9'h11);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 64'h22, 9'h12);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 64'h33, 9'h13);
        check("flush_two_valid", 64'(vout[0]), 64'd0);
        check("flush_two_ctrl", 64'(cout[0]), 64'd0);
        check("flush_two_ready", 64'(rout[0]), 64'd1);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 64'h44, 9'h14);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 64'h55, 9'h15);
        idle(3);

        // Reset asserted for one cycle in state ONE.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 64'h1234_5678_9ABC_DEF0, 9'h0F5);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 64'd0, 9'd0);
        check_reset_values("rst_one");

        // Full-width entry on the 64/9 instance.
        drive(1'b1, 1'b1, 1'b0, 1'b0, 64'hFFFF_FFFF_0000_0001, 9'h1FF);
        check("wide_data", dout[2], 64'hFFFF_FFFF_0000_0001);
        check("wide_ctrl", 64'(cout[2]), 64'h1FF);
        idle(3);

        // Randomised traffic with occasional flush.
        for (int i = 0; i < 1000; i++) begin
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 63) == 0), 1'b0,
                  {$urandom, $urandom}, 9'($urandom));
        end
        idle(6);

        sb_en = 1'b0;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
